// File: rtl/drac_icache_pkg.sv
// Shared types and sizes for the instruction-cache way controller.
// Holds array geometry, the controller state enum and the PLRU tree type.
package drac_icache_pkg;

   localparam int ICACHE_N_WAY = 4;
   localparam int ICACHE_DEPTH = 256;
   localparam int ADDR_WIDHT   = 8;
   localparam int SET_WIDHT    = 128;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } ctrl_state_t;

   // Tree bits packed as {b0, b1, b2}: b0 picks the half, b1/b2 pick within it.
   typedef logic [2:0] plru_t;

   // One-hot of the lowest-index clear bit; all zeros when every way is valid.
   function automatic logic [ICACHE_N_WAY-1:0] first_free_way(input logic [ICACHE_N_WAY-1:0] valid);
      first_free_way = '0;
      for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            first_free_way    = '0;
            first_free_way[i] = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/icache_plru_tree.sv
// Combinational victim selection and access update for one 4-way 3-bit tree PLRU.
// Victim depends only on the current tree so it can feed access_way without a loop.
module icache_plru_tree
   import drac_icache_pkg::*;
(
   input  plru_t      state,
   input  logic [3:0] access_way,
   output logic [3:0] victim,
   output plru_t      next_state
);

   always_comb begin
      victim = 4'b0000;
      if (!state[2]) begin
         victim = state[1] ? 4'b0010 : 4'b0001;
      end else begin
         victim = state[0] ? 4'b1000 : 4'b0100;
      end
   end

   always_comb begin
      next_state = state;
      casez (access_way)
         4'b???1: begin next_state[2] = 1'b1; next_state[1] = 1'b1; end
         4'b??10: begin next_state[2] = 1'b1; next_state[1] = 1'b0; end
         4'b?100: begin next_state[2] = 1'b0; next_state[0] = 1'b1; end
         4'b1000: begin next_state[2] = 1'b0; next_state[0] = 1'b0; end
         default: next_state = state;
      endcase
   end

endmodule

// File: rtl/icache_way_ctrl.sv
// Way sequencer/arbiter for the 4-way icache data array: valid bits, replacement, flush sweep.
// ICACHE_PLRU_EN selects per-set tree PLRU; otherwise a global 2-bit round-robin counter.
module icache_way_ctrl
   import drac_icache_pkg::*;
#(
   parameter int N_WAY  = ICACHE_N_WAY,
   parameter int DEPTH  = ICACHE_DEPTH,
   parameter int ADDR_W = ADDR_WIDHT,
   parameter int SET_W  = SET_WIDHT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lookup_valid_i,
   input  logic [ADDR_W-1:0] lookup_addr_i,
   output logic              lookup_ready_o,
   input  logic              hit_valid_i,
   input  logic [ADDR_W-1:0] hit_addr_i,
   input  logic [N_WAY-1:0]  hit_way_i,
   input  logic              refill_valid_i,
   input  logic [ADDR_W-1:0] refill_addr_i,
   input  logic [SET_W-1:0]  refill_data_i,
   output logic              refill_ready_o,
   input  logic              flush_i,
   output logic              flush_busy_o,
   output logic              flush_done_o,
   output logic [N_WAY-1:0]  mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [SET_W-1:0]  mem_data_o,
   output logic [N_WAY-1:0]  victim_way_o,
   output logic [N_WAY-1:0]  valid_o
);

   ctrl_state_t       state_q, state_d;
   logic [ADDR_W-1:0] count_q;
   logic              last_set;
   logic [N_WAY-1:0]  valid_q [DEPTH];
   logic              rd_pend_q;

   logic              refill_acc, lookup_acc;
   logic [N_WAY-1:0]  set_valid, policy_victim, victim;
   logic              all_valid;

   assign last_set = (count_q == ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FLUSH) begin
            count_q <= last_set ? '0 : count_q + 1'b1;
         end else begin
            count_q <= '0;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      refill_ready_o = 1'b0;
      lookup_ready_o = 1'b0;
      flush_busy_o   = 1'b0;
      flush_done_o   = 1'b0;
      case (state_q)
         IDLE: begin
            refill_ready_o = !flush_i && !rst_i;
            lookup_ready_o = !flush_i && !rst_i && !refill_valid_i;
            if (flush_i) state_d = FLUSH;
         end
         FLUSH: begin
            flush_busy_o = 1'b1;
            flush_done_o = last_set;
            if (last_set) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign refill_acc = refill_valid_i && refill_ready_o;
   assign lookup_acc = lookup_valid_i && lookup_ready_o;
   assign set_valid  = valid_q[refill_addr_i];
   assign all_valid  = &set_valid;
   assign victim     = all_valid ? policy_victim : first_free_way(set_valid);

`ifdef ICACHE_PLRU_EN
   plru_t            plru_q [DEPTH];
   plru_t            refill_plru_next, hit_plru_next;
   logic [N_WAY-1:0] unused_hit_victim;

   icache_plru_tree u_refill_tree (
      .state      (plru_q[refill_addr_i]),
      .access_way (victim),
      .victim     (policy_victim),
      .next_state (refill_plru_next)
   );

   icache_plru_tree u_hit_tree (
      .state      (plru_q[hit_addr_i]),
      .access_way (hit_way_i),
      .victim     (unused_hit_victim),
      .next_state (hit_plru_next)
   );

   // Refill update is written last so it wins when both target the same set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) plru_q[i] <= '0;
      end else if (state_q == FLUSH) begin
         plru_q[count_q] <= '0;
      end else begin
         if (hit_valid_i) plru_q[hit_addr_i] <= hit_plru_next;
         if (refill_acc)  plru_q[refill_addr_i] <= refill_plru_next;
      end
   end
`else
   logic [1:0] rr_q;
   logic       unused_hit;

   assign unused_hit    = ^{hit_valid_i, hit_addr_i, hit_way_i};
   assign policy_victim = N_WAY'(1) << rr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q <= '0;
      end else if (refill_acc && all_valid) begin
         rr_q <= rr_q + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) valid_q[i] <= '0;
      end else if (state_q == FLUSH) begin
         valid_q[count_q] <= '0;
      end else if (refill_acc) begin
         valid_q[refill_addr_i] <= set_valid | victim;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_req_o    <= '0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         victim_way_o <= '0;
         valid_o      <= '0;
         rd_pend_q    <= 1'b0;
      end else begin
         mem_req_o <= '0;
         mem_we_o  <= 1'b0;
         rd_pend_q <= 1'b0;
         if (refill_acc) begin
            mem_req_o    <= victim;
            mem_we_o     <= 1'b1;
            mem_addr_o   <= refill_addr_i;
            mem_data_o   <= refill_data_i;
            victim_way_o <= victim;
         end else if (lookup_acc) begin
            mem_req_o  <= '1;
            mem_addr_o <= lookup_addr_i;
            rd_pend_q  <= 1'b1;
         end
         // Valid bits land one cycle after the array request, alongside the read data.
         if (rd_pend_q) valid_o <= valid_q[mem_addr_o];
      end
   end

endmodule
